// File: rtl/data_sram_resp.sv
// Data-SRAM responder for the core's data_sram port: byte-masked writes, registered reads,
// optional wait states. Define DSRAM_ERR_EN to add out-of-range detection and the addr_err output.
module data_sram_resp #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_mem,
`ifdef DSRAM_ERR_EN
  output logic        addr_err,
`endif
  output logic        busy
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [2:0] WAIT_N = 3'(WAIT_CYCLES);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  logic [31:0]       mem_q [DEPTH];
  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              err_pend_q, err_pend_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [ADDR_W-1:0] idx_s;
  logic              rd_s;
  logic              accept_s;
  logic              oor_s;
  logic              wr_fire_s;
  logic              unused_s;

  assign idx_s    = data_sram_addr[ADDR_W+1:2];
  assign rd_s     = (data_sram_wen == 4'b0000);
  assign accept_s = (state_q == ST_IDLE) && data_sram_en;

`ifdef DSRAM_ERR_EN
  assign oor_s    = |data_sram_addr[31:ADDR_W+2];
  assign unused_s = ^data_sram_addr[1:0];
`else
  // Upper address bits alias onto the array; byte offset is MEM's concern.
  assign oor_s    = 1'b0;
  assign unused_s = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0], err_q};
`endif

  assign wr_fire_s = accept_s && !rd_s && !oor_s;

  // Byte-lane write port; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire_s) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) begin
          mem_q[idx_s][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Next-state and read-data selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_pend_d  = rd_pend_q;
    err_pend_d = err_pend_q;
    idx_d      = idx_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (WAIT_CYCLES == 0) begin
            if (rd_s) begin
              rdata_d = oor_s ? 32'h0000_0000 : mem_q[idx_s];
            end else begin
              rdata_d = rdata_q;
            end
            err_d = oor_s;
          end else begin
            state_d    = ST_WAIT;
            cnt_d      = WAIT_N;
            rd_pend_d  = rd_s;
            err_pend_d = oor_s;
            idx_d      = idx_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd1) begin
          // Final wait edge: the array already holds any earlier write, so read it now.
          state_d    = ST_IDLE;
          cnt_d      = 3'd0;
          rd_pend_d  = 1'b0;
          err_pend_d = 1'b0;
          err_d      = err_pend_q;
          if (rd_pend_q) begin
            rdata_d = err_pend_q ? 32'h0000_0000 : mem_q[idx_q];
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      rd_pend_q  <= 1'b0;
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= {ADDR_W{1'b0}};
      rdata_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      err_pend_q <= err_pend_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      rdata_q    <= rdata_d;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign busy            = (state_q == ST_WAIT);
  assign stallreq_mem    = (state_q == ST_WAIT);
`ifdef DSRAM_ERR_EN
  assign addr_err        = err_q;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: three instances (0, 2 and 3 wait states) against a word-array model.
module tb_data_sram_resp;

  localparam int AW = 16;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        en    [3];
  logic [3:0]  wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        stall [3];
  logic        busy  [3];
  logic        err   [3];

  logic [31:0] mdl    [3][64];
  logic [31:0] exp_rd [3];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_n0 (
    .clk(clk), .rst(rst[0]), .data_sram_en(en[0]), .data_sram_wen(wen[0]),
    .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]), .data_sram_rdata(rdata[0]),
    .stallreq_mem(stall[0]),
`ifdef DSRAM_ERR_EN
    .addr_err(err[0]),
`endif
    .busy(busy[0]));

  data_sram_resp #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_n2 (
    .clk(clk), .rst(rst[1]), .data_sram_en(en[1]), .data_sram_wen(wen[1]),
    .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]), .data_sram_rdata(rdata[1]),
    .stallreq_mem(stall[1]),
`ifdef DSRAM_ERR_EN
    .addr_err(err[1]),
`endif
    .busy(busy[1]));

  data_sram_resp #(.ADDR_W(AW), .WAIT_CYCLES(3)) u_n3 (
    .clk(clk), .rst(rst[2]), .data_sram_en(en[2]), .data_sram_wen(wen[2]),
    .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]), .data_sram_rdata(rdata[2]),
    .stallreq_mem(stall[2]),
`ifdef DSRAM_ERR_EN
    .addr_err(err[2]),
`endif
    .busy(busy[2]));

`ifndef DSRAM_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
  assign err[2] = 1'b0;
`endif

  function automatic int nw(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  // Word address in the modelled window with random byte offset (and random alias bits).
  function automatic logic [31:0] mk_addr(input int w);
    logic [31:0] a;
    a = {24'h000000, 6'(w), 2'($urandom_range(3))};
`ifndef DSRAM_ERR_EN
    a[31:18] = 14'($urandom);
`endif
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_apply(input int d, input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd);
    int k;
    k = int'(a[7:2]);
    if (w == 4'b0000) begin
      exp_rd[d] = mdl[d][k];
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w[i]) mdl[d][k][8*i +: 8] = wd[8*i +: 8];
      end
    end
  endtask

  task automatic issue(input int d, input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd);
    en[d] = 1'b1; wen[d] = w; addr[d] = a; wdata[d] = wd;
    mdl_apply(d, w, a, wd);
  endtask

  task automatic do_access(input int d, input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd);
    issue(d, w, a, wd);
    step();
    en[d] = 1'b0;
    repeat (nw(d)) step();
  endtask

  task automatic test_reset();
    step(); step();
    for (int d = 0; d < 3; d++) begin
      total++; if (rdata[d] !== 32'h0) begin bad++; $display("FAIL reset_rdata d%0d: got %h want 0", d, rdata[d]); end
      total++; if (stall[d] !== 1'b0) begin bad++; $display("FAIL reset_stall d%0d: got %b want 0", d, stall[d]); end
      total++; if (busy[d] !== 1'b0) begin bad++; $display("FAIL reset_busy d%0d: got %b want 0", d, busy[d]); end
      total++; if (err[d] !== 1'b0) begin bad++; $display("FAIL reset_err d%0d: got %b want 0", d, err[d]); end
      rst[d] = 1'b0;
      exp_rd[d] = 32'h0;
    end
  endtask

  task automatic init_mem();
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 64; w++)
        do_access(d, 4'hF, mk_addr(w), $urandom);
  endtask

  task automatic test_n0_basic();
    issue(0, 4'hF, 32'h0000_0010, 32'hDEADBEEF); step();
    total++; if (stall[0] !== 1'b0) begin bad++; $display("FAIL n0_stall_w: got %b want 0", stall[0]); end
    issue(0, 4'h0, 32'h0000_0010, 32'h0); step(); en[0] = 1'b0;
    total++; if (rdata[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL n0_rd_after_wr: got %h want DEADBEEF", rdata[0]); end
    total++; if (stall[0] !== 1'b0) begin bad++; $display("FAIL n0_stall_r: got %b want 0", stall[0]); end
    issue(0, 4'b0100, 32'h0000_0010, 32'h00AA0000); step();
    issue(0, 4'h0, 32'h0000_0010, 32'h0); step(); en[0] = 1'b0;
    total++; if (rdata[0] !== 32'hDEAABEEF) begin bad++; $display("FAIL n0_lane2: got %h want DEAABEEF", rdata[0]); end
    issue(0, 4'b0011, 32'h0000_0010, 32'h00001234); step();
    issue(0, 4'h0, 32'h0000_0010, 32'h0); step(); en[0] = 1'b0;
    total++; if (rdata[0] !== 32'hDEAA1234) begin bad++; $display("FAIL n0_lane10: got %h want DEAA1234", rdata[0]); end
  endtask

  task automatic test_random_n0();
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(3) != 0) begin
        issue(0, ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom), mk_addr($urandom_range(63)), $urandom);
      end else begin
        en[0] = 1'b0; addr[0] = $urandom; wen[0] = 4'($urandom);
      end
      step();
      total++; if (rdata[0] !== exp_rd[0]) begin bad++; $display("FAIL rnd0_rdata it%0d: got %h want %h", it, rdata[0], exp_rd[0]); end
      total++; if ((stall[0] | busy[0] | err[0]) !== 1'b0) begin bad++; $display("FAIL rnd0_stall it%0d: got %b%b%b want 000", it, stall[0], busy[0], err[0]); end
    end
    en[0] = 1'b0;
  endtask

  task automatic test_wait2();
    logic [31:0] v;
    logic        prev_busy;
    int          rises;
    v = $urandom;
    do_access(1, 4'hF, 32'h0000_0010, v);
    issue(1, 4'h0, 32'h0000_0010, 32'h0);
    prev_busy = busy[1];
    rises = 0;
    // Accepted at edge T (k=0) and again at T+3; each access stalls two cycles.
    for (int k = 0; k < 6; k++) begin
      step();
      total++; if (stall[1] !== ((k % 3) != 2)) begin bad++; $display("FAIL w2_stall k%0d: got %b want %b", k, stall[1], (k % 3) != 2); end
      if ((k % 3) == 2) begin
        total++; if (rdata[1] !== v) begin bad++; $display("FAIL w2_rdata k%0d: got %h want %h", k, rdata[1], v); end
      end
      if (busy[1] && !prev_busy) rises++;
      prev_busy = busy[1];
    end
    en[1] = 1'b0;
    total++; if (rises !== 2) begin bad++; $display("FAIL w2_accepts: got %0d want 2", rises); end
  endtask

  task automatic test_random_wait(input int d);
    logic [31:0] old;
    for (int it = 0; it < 25; it++) begin
      old = exp_rd[d];
      issue(d, ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom), mk_addr($urandom_range(63)), $urandom);
      step();
      for (int j = 1; j <= nw(d); j++) begin
        total++; if ({stall[d], busy[d]} !== 2'b11) begin bad++; $display("FAIL rw%0d_stall it%0d j%0d: got %b%b want 11", d, it, j, stall[d], busy[d]); end
        total++; if (rdata[d] !== old) begin bad++; $display("FAIL rw%0d_hold it%0d j%0d: got %h want %h", d, it, j, rdata[d], old); end
        // Requests presented during wait states must be ignored.
        en[d] = 1'b1; wen[d] = 4'($urandom); addr[d] = $urandom; wdata[d] = $urandom;
        step();
      end
      en[d] = 1'b0;
      total++; if ({stall[d], busy[d]} !== 2'b00) begin bad++; $display("FAIL rw%0d_done it%0d: got %b%b want 00", d, it, stall[d], busy[d]); end
      total++; if (rdata[d] !== exp_rd[d]) begin bad++; $display("FAIL rw%0d_rdata it%0d: got %h want %h", d, it, rdata[d], exp_rd[d]); end
    end
  endtask

  task automatic test_reset_midwait();
    logic [31:0] v;
    v = $urandom;
    do_access(2, 4'hF, 32'h0000_0020, v);
    do_access(2, 4'hF, 32'h0000_0014, 32'hCAFEF00D);
    do_access(2, 4'h0, 32'h0000_0014, 32'h0);
    issue(2, 4'h0, 32'h0000_0020, 32'h0); step();
    en[2] = 1'b0; step();
    rst[2] = 1'b1; step();
    rst[2] = 1'b0;
    exp_rd[2] = 32'h0;
    total++; if ({stall[2], busy[2]} !== 2'b00) begin bad++; $display("FAIL mid_rst_stall: got %b%b want 00", stall[2], busy[2]); end
    total++; if (rdata[2] !== 32'h0) begin bad++; $display("FAIL mid_rst_rdata: got %h want 0", rdata[2]); end
    do_access(2, 4'h0, 32'h0000_0020, 32'h0);
    total++; if (rdata[2] !== v) begin bad++; $display("FAIL mid_rst_keep: got %h want %h", rdata[2], v); end
  endtask

`ifdef DSRAM_ERR_EN
  task automatic test_err();
    en[0] = 1'b1; wen[0] = 4'hF; addr[0] = 32'h8000_0000; wdata[0] = 32'h0000_0055; step();
    en[0] = 1'b0;
    total++; if (err[0] !== 1'b1) begin bad++; $display("FAIL err_wr_pulse: got %b want 1", err[0]); end
    step();
    total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL err_wr_end: got %b want 0", err[0]); end
    issue(0, 4'h0, 32'h0000_0000, 32'h0); step();
    total++; if (rdata[0] !== mdl[0][0]) begin bad++; $display("FAIL err_word0: got %h want %h", rdata[0], mdl[0][0]); end
    en[0] = 1'b1; wen[0] = 4'h0; addr[0] = 32'h8000_0000; step();
    en[0] = 1'b0;
    total++; if (rdata[0] !== 32'h0) begin bad++; $display("FAIL err_rd_zero: got %h want 0", rdata[0]); end
    total++; if (err[0] !== 1'b1) begin bad++; $display("FAIL err_rd_pulse: got %b want 1", err[0]); end
    step();
    total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL err_rd_end: got %b want 0", err[0]); end
    exp_rd[0] = 32'h0;
    do_access(1, 4'hF, 32'h0000_0004, 32'h1234_5678);
    do_access(1, 4'h0, 32'h0000_0004, 32'h0);
    en[1] = 1'b1; wen[1] = 4'h0; addr[1] = 32'h8000_0004; step();
    en[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (err[1] !== (k == 2)) begin bad++; $display("FAIL err_w2 k%0d: got %b want %b", k, err[1], k == 2); end
      if (k == 2) begin
        total++; if (rdata[1] !== 32'h0) begin bad++; $display("FAIL err_w2_rdata: got %h want 0", rdata[1]); end
      end
      step();
    end
    exp_rd[1] = 32'h0;
  endtask
`endif

  task automatic test_reset_retain();
    int w;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 8; i++)
        do_access(d, ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom), mk_addr($urandom_range(63)), $urandom);
    for (int d = 0; d < 3; d++) rst[d] = 1'b1;
    step(); step();
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0;
      exp_rd[d] = 32'h0;
      total++; if ({rdata[d], stall[d], busy[d]} !== 34'h0) begin bad++; $display("FAIL rr_zero d%0d: got %h %b %b want 0 0 0", d, rdata[d], stall[d], busy[d]); end
    end
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 6; i++) begin
        w = $urandom_range(63);
        do_access(d, 4'h0, mk_addr(w), 32'h0);
        total++; if (rdata[d] !== mdl[d][w]) begin bad++; $display("FAIL rr_keep d%0d w%0d: got %h want %h", d, w, rdata[d], mdl[d][w]); end
      end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; en[d] = 1'b0; wen[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0; exp_rd[d] = 32'h0;
    end
    test_reset();
    init_mem();
    test_n0_basic();
    test_random_n0();
    test_wait2();
    test_random_wait(1);
    test_random_wait(2);
    test_reset_midwait();
`ifdef DSRAM_ERR_EN
    test_err();
`endif
    test_reset_retain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
